// File: rtl/servo_pwm_bank.sv
// Multi-channel frame-synchronous hobby-servo PWM generator with per-channel target write port.
// Optional build macro SERVO_SLEW_EN: slew-limit each channel's applied offset by SLEW_STEP per frame.
module servo_pwm_bank #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PERIOD_CYCLES = 2000000,
  parameter int unsigned MIN_PULSE     = 70000,
  parameter int unsigned OFF_W         = 18,
  parameter int unsigned MAX_OFFSET    = 180000,
  parameter int unsigned SLEW_STEP     = 5000,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [OFF_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] servo,
  output logic              frame_start,
  output logic [NUM_CH-1:0] at_target
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
  localparam int unsigned CMP_W = (CNT_W > OFF_W + 1) ? CNT_W : OFF_W + 1;

  // Elaboration-time parameter sanity: every pulse must fall inside its frame.
  if (MIN_PULSE + MAX_OFFSET >= PERIOD_CYCLES) begin : g_bad_timing
    $error("servo_pwm_bank: MIN_PULSE + MAX_OFFSET must be below PERIOD_CYCLES");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_pwm_bank: NUM_CH must be in 1..16");
  end
  if (MAX_OFFSET >= (64'd1 << OFF_W) || SLEW_STEP >= (64'd1 << OFF_W)) begin : g_bad_off_w
    $error("servo_pwm_bank: MAX_OFFSET and SLEW_STEP must fit in OFF_W bits");
  end

  logic [CNT_W-1:0] counter;
  logic             boundary;
  logic [OFF_W-1:0] target      [NUM_CH];
  logic [OFF_W-1:0] applied     [NUM_CH];
  logic [OFF_W-1:0] applied_nxt [NUM_CH];
  logic [CMP_W-1:0] thresh      [NUM_CH];
  logic [NUM_CH-1:0] en_lat;
  logic [OFF_W-1:0] wr_clamped;
  logic             wr_hit;

  assign boundary   = (counter == CNT_W'(PERIOD_CYCLES - 1));
  assign wr_clamped = (wr_data > OFF_W'(MAX_OFFSET)) ? OFF_W'(MAX_OFFSET) : wr_data;
  assign wr_hit     = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH));

  // Frame period counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
    end else if (boundary) begin
      counter <= '0;
    end else begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Target registers: last accepted write in a frame wins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) target[ch] <= '0;
    end else if (wr_hit) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_ch == CH_W'(ch)) target[ch] <= wr_clamped;
      end
    end
  end

`ifdef SERVO_SLEW_EN
  localparam logic [OFF_W-1:0] STEP = OFF_W'(SLEW_STEP);

  // Move applied toward target by at most STEP per frame
  always_comb begin
    logic [OFF_W-1:0] delta;
    delta = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      applied_nxt[ch] = applied[ch];
      if (target[ch] > applied[ch]) begin
        delta           = target[ch] - applied[ch];
        applied_nxt[ch] = applied[ch] + ((delta > STEP) ? STEP : delta);
      end else if (target[ch] < applied[ch]) begin
        delta           = applied[ch] - target[ch];
        applied_nxt[ch] = applied[ch] - ((delta > STEP) ? STEP : delta);
      end
    end
  end
`else
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) applied_nxt[ch] = target[ch];
  end
`endif

  // Applied offset and enable only change at the frame boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) applied[ch] <= '0;
      en_lat <= '0;
    end else if (boundary) begin
      for (int ch = 0; ch < NUM_CH; ch++) applied[ch] <= applied_nxt[ch];
      en_lat <= ch_en;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      thresh[ch] = CMP_W'(MIN_PULSE) + CMP_W'(applied[ch]);
    end
  end

  // Registered pulse outputs and frame marker
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      servo       <= '0;
      frame_start <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        servo[ch] <= en_lat[ch] && (CMP_W'(counter) < thresh[ch]);
      end
      frame_start <= (counter == '0);
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) at_target[ch] = (applied[ch] == target[ch]);
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: per-frame pulse widths checked against a queue of expectations.
// Build with SERVO_SLEW_EN defined to exercise the slew-limited variant.
module tb_servo_pwm_bank;

  localparam int unsigned NCH  = 2;
  localparam int unsigned PER  = 100;
  localparam int unsigned MINP = 10;
  localparam int unsigned OFFW = 18;
  localparam int unsigned MAXO = 40;
  localparam int unsigned STEP = 5;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_en   = 1'b0;
  logic [0:0]      wr_ch   = '0;
  logic [OFFW-1:0] wr_data = '0;
  logic [NCH-1:0]  ch_en   = 2'b11;
  logic [NCH-1:0]  servo;
  logic            frame_start;
  logic [NCH-1:0]  at_target;

  servo_pwm_bank #(
    .NUM_CH(NCH), .PERIOD_CYCLES(PER), .MIN_PULSE(MINP),
    .OFF_W(OFFW), .MAX_OFFSET(MAXO), .SLEW_STEP(STEP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .ch_en(ch_en), .servo(servo),
    .frame_start(frame_start), .at_target(at_target)
  );

  always #5 clock = ~clock;

  typedef struct { int fid; int w0; int w1; } exp_t;
  exp_t sb[$];

  int vecs = 0;
  int miscompares = 0;
  int fid = 0;
  int cyc = 0;
  bit in_frame = 1'b0;
  int cnt[NCH];
  int first[NCH];
  int last[NCH];

  // Close out a measured frame and compare it with its queued expectation
  task automatic finalize_frame();
    exp_t e;
    int w;
    vecs++;
    if (cyc + 1 != PER) begin
      miscompares++;
      $display("FAIL frame_period frame=%0d got=%0d want=%0d", fid, cyc + 1, PER);
    end
    while (sb.size() > 0 && sb[0].fid < fid) begin
      e = sb.pop_front();
      miscompares++;
      $display("FAIL frame_missed frame=%0d never measured", e.fid);
    end
    if (sb.size() > 0 && sb[0].fid == fid) begin
      e = sb.pop_front();
      for (int ch = 0; ch < NCH; ch++) begin
        w = (ch == 0) ? e.w0 : e.w1;
        vecs++;
        if (cnt[ch] !== w) begin
          miscompares++;
          $display("FAIL pulse_width frame=%0d ch=%0d got=%0d want=%0d", fid, ch, cnt[ch], w);
        end
        if (w > 0) begin
          vecs++;
          if (first[ch] !== 0 || last[ch] !== w - 1) begin
            miscompares++;
            $display("FAIL pulse_shape frame=%0d ch=%0d first=%0d last=%0d want 0..%0d",
                     fid, ch, first[ch], last[ch], w - 1);
          end
        end
      end
    end
  endtask

  task automatic monitor_step();
    if (!reset_n) begin
      fid = 0;
      cyc = 0;
      in_frame = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_frame) finalize_frame();
        fid++;
        in_frame = 1'b1;
        cyc = 0;
        for (int ch = 0; ch < NCH; ch++) begin
          cnt[ch] = 0; first[ch] = -1; last[ch] = -1;
        end
      end else if (in_frame) begin
        cyc++;
      end
      if (in_frame) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (servo[ch]) begin
            if (first[ch] < 0) first[ch] = cyc;
            last[ch] = cyc;
            cnt[ch]++;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clock);
    monitor_step();
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_frame(input int n);
    int b = 0;
    while (fid < n && b < 1000) begin
      tick();
      b++;
    end
    if (fid < n) begin
      vecs++;
      miscompares++;
      $display("FAIL wait_frame timeout got=%0d want=%0d", fid, n);
    end
  endtask

  // Return while the internal counter equals c (1..99)
  task automatic wait_cnt(input int c);
    int b = 0;
    do begin
      tick();
      b++;
    end while (!(in_frame && cyc + 1 == c) && b < 300);
    if (!(in_frame && cyc + 1 == c)) begin
      vecs++;
      miscompares++;
      $display("FAIL wait_cnt timeout want=%0d", c);
    end
  endtask

  task automatic write(input int ch, input int data);
    wr_en   = 1'b1;
    wr_ch   = 1'(ch);
    wr_data = OFFW'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_at_target(input string tag, input logic [NCH-1:0] want);
    vecs++;
    if (at_target !== want) begin
      miscompares++;
      $display("FAIL %s at_target got=%b want=%b", tag, at_target, want);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ch_en   = 2'b11;
    wr_en   = 1'b0;
    repeat (3) tick();
    vecs += 2;
    if (servo !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_servo got=%b want=00", servo);
    end
    if (frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_start got=%b want=0", frame_start);
    end
    check_at_target("reset", 2'b11);
    sb.push_back('{1, 0, 0});
    sb.push_back('{2, 10, 10});
    sb.push_back('{3, 10, 10});
    reset_n = 1'b1;
    wait_frame(4);
    check_at_target("reset_idle", 2'b11);
  endtask

  task automatic test_write_clamp();
    int f = fid;
    sb.push_back('{f, 10, 10});
    sb.push_back('{f + 1, 35, 50});
    sb.push_back('{f + 2, 35, 50});
    wait_cnt(30);
    write(0, 25);
    write(1, 99);
    check_at_target("write_pending", 2'b00);
    wait_frame(f + 1);
    check_at_target("write_applied", 2'b11);
    wait_frame(f + 3);
  endtask

  task automatic test_boundary_race();
    int g = fid;
    sb.push_back('{g, 35, 50});
    sb.push_back('{g + 1, 35, 50});
    sb.push_back('{g + 2, 30, 50});
    wait_cnt(99);
    write(0, 20);
    check_at_target("race_after_edge", 2'b10);
    wait_frame(g + 1);
    check_at_target("race_next_frame", 2'b10);
    wait_frame(g + 2);
    check_at_target("race_applied", 2'b11);
    wait_frame(g + 3);
  endtask

  task automatic test_disable();
    int h = fid;
    sb.push_back('{h, 30, 50});
    sb.push_back('{h + 1, 30, 0});
    sb.push_back('{h + 2, 30, 50});
    wait_cnt(5);
    ch_en = 2'b01;
    wait_frame(h + 1);
    ch_en = 2'b11;
    wait_frame(h + 3);
  endtask

  task automatic test_slew();
    int s = fid;
    sb.push_back('{s, 10, 10});
    sb.push_back('{s + 1, 15, 10});
    sb.push_back('{s + 2, 20, 10});
    sb.push_back('{s + 3, 25, 10});
    sb.push_back('{s + 4, 27, 10});
    wait_cnt(40);
    write(0, 17);
    wait_frame(s + 3);
    check_at_target("slew_third", 2'b10);
    wait_frame(s + 4);
    check_at_target("slew_done", 2'b11);
    wait_frame(s + 5);
  endtask

  task automatic test_async_reset();
    wait_frame(fid + 1);
    wait_cnt(7);
    vecs++;
    if (servo !== 2'b11) begin
      miscompares++;
      $display("FAIL async_pre servo got=%b want=11", servo);
    end
    reset_n = 1'b0;
    #1;
    vecs += 2;
    if (servo !== 2'b00) begin
      miscompares++;
      $display("FAIL async_servo got=%b want=00", servo);
    end
    if (frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL async_frame_start got=%b want=0", frame_start);
    end
    check_at_target("async", 2'b11);
    repeat (3) tick();
    sb.push_back('{1, 0, 0});
    sb.push_back('{2, 10, 10});
    reset_n = 1'b1;
    wait_frame(3);
  endtask

  initial begin
    test_reset();
`ifdef SERVO_SLEW_EN
    test_slew();
`else
    test_write_clamp();
    test_boundary_race();
    test_disable();
`endif
    test_async_reset();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vecs++;
      miscompares++;
      $display("FAIL frame_unchecked frame=%0d want=%0d/%0d", e.fid, e.w0, e.w1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
